bsg_manycore_host_ep_responder: RTL and testbench
=================================================

Name: bsg_manycore_host_ep_responder

Overview:
- Synthesizable host-side endpoint that terminates remote requests addressed to the host tile (BSG_MACHINE_HOST_X/Y_CORD).
- It is the responder opposite the host I/O loader's initiator path.
- Decodes incoming load/store packets against a fixed EPA map: scratch words, print-stat, putchar, finish, fail.
- Returns one response per request (load data or store ack) through a 2-entry response FIFO.
- Sits between the host link adapter and testbench/FPGA status logic.

Parameters:
- addr_width_p, 28, EPA word-address width.
- data_width_p, 32, payload width; mask width is data_width_p/8.
- x_cord_width_p, 7, X coordinate width.
- y_cord_width_p, 7, Y coordinate width.
- scratch_words_p, 16, scratch register-file depth (power of 2), EPA words 0..scratch_words_p-1.
- print_stat_epa_p, 'h0D0C, word EPA of the print-stat register.
- putchar_epa_p, 'h1000, word EPA of the putchar register.
- finish_epa_p, 'h3AB4, word EPA of the finish register.
- fail_epa_p, 'h3AB8, word EPA of the fail register.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- req_v_i  in  1  request valid.
- req_ready_o  out  1  request ready. Transfer occurs when req_v_i & req_ready_o.
- req_op_i  in  2  request op: 0 load, 1 store, 2/3 reserved (treated as store).
- req_addr_i  in  addr_width_p  word EPA.
- req_data_i  in  data_width_p  store data.
- req_mask_i  in  data_width_p/8  store byte mask.
- req_reg_id_i  in  5  load destination register id.
- req_src_x_i  in  x_cord_width_p  source X coordinate.
- req_src_y_i  in  y_cord_width_p  source Y coordinate.
- resp_v_o  out  1  response valid.
- resp_yumi_i  in  1  consumer accepts the head response.
- resp_type_o  out  1  0 = write ack, 1 = load data.
- resp_data_o  out  data_width_p  load data (0 for acks).
- resp_reg_id_o  out  5  echoed reg id.
- resp_dst_x_o  out  x_cord_width_p  echoed source X.
- resp_dst_y_o  out  y_cord_width_p  echoed source Y.
- print_stat_v_o  out  1  one-cycle pulse on a print-stat store.
- print_stat_tag_o  out  data_width_p  tag for the pulse; valid only with print_stat_v_o.
- putchar_v_o  out  1  one-cycle pulse on a putchar store.
- putchar_o  out  8  data[7:0] of the putchar store.
- finish_o  out  1  sticky finish flag.
- fail_o  out  1  sticky fail flag.
- exit_code_o  out  data_width_p  data of the first finish or fail store.
- req_count_o  out  32  accepted-request counter.

Behaviour:
- Reset (reset_n_i low, asynchronous):
  - FIFO empty; resp_v_o=0; req_ready_o=1 once reset is released.
  - All pulse outputs, flags, exit_code_o, req_count_o and scratch cleared to 0.
- Acceptance:
  - req_ready_o = FIFO not full. Ready depends only on registered FIFO state, never combinationally on resp_yumi_i.
- Latency:
  - A request accepted in cycle t produces its entry at the FIFO tail at the edge ending t.
  - If the FIFO was empty, resp_v_o=1 in cycle t+1.
  - Side-effect pulses (print_stat_v_o, putchar_v_o) are registered and assert in cycle t+1 for exactly one cycle.
- Decode:
  - Address matches are exact compares on the full req_addr_i.
  - Scratch hit = req_addr_i < scratch_words_p.
- Loads:
  - Scratch hit returns the scratch word.
  - print_stat_epa_p returns 0.
  - finish_epa_p returns {31'b0,finish}; fail_epa_p returns {31'b0,fail}.
  - Any other address returns 'hDEAD_BEEF.
  - resp_type=1.
- Stores:
  - Scratch hit performs a byte-masked write; the mask applies only to scratch.
  - Special EPAs ignore the mask and act on full data.
  - Unmapped stores are dropped.
  - Every store produces an ack: resp_type=0, data 0.
- Finish/fail:
  - The first of either store sets its flag and captures exit_code_o.
  - Later finish/fail stores set their own flag but do not change exit_code_o.
  - If finish and fail are both set, both outputs stay high.
- FIFO: 2 entries. Simultaneous enqueue and dequeue when full is not allowed, since ready is 0 when full. When one entry is held, simultaneous enq+deq keeps the count at 1.
- req_count_o increments on each accepted request and wraps from 'hFFFF_FFFF to 0.
- Load-after-store to the same scratch word on back-to-back cycles returns the new data (the write completes at the edge ending the store cycle).
- Reset asserted mid-operation discards queued responses and clears all outputs immediately (asynchronous).

Decomposition:
- Shared package bsg_manycore_host_ep_pkg holds:
  - host_ep_op_e (load/store).
  - host_ep_resp_type_e.
  - EPA constant defaults.
  - The DEAD_BEEF constant.
- Sub-module bsg_manycore_host_ep_resp_fifo: 2-entry FIFO, async active-low reset, valid/yumi output.

Test Plan:
1. Store 'h1234_5678 mask 'hF to EPA 3, then load EPA 3 from (x=2,y=5) reg 7 -> ack (type 0), then load response data 'h1234_5678, reg_id 7, dst 2/5.
2. Store 'hAABB_CCDD mask 'b0101 to EPA 4 over prior 0 -> load returns 'h00BB_00DD.
3. Store 'h2A to putchar_epa_p, then 'h7 to print_stat_epa_p -> putchar_v_o pulse with 'h2A, then print_stat_v_o pulse with tag 7, each one cycle.
4. Store 5 to finish_epa_p, then 9 to fail_epa_p -> finish_o=1, fail_o=1, exit_code_o=5; load finish_epa_p returns 1.
5. Hold resp_yumi_i=0 and issue 3 requests -> req_ready_o falls after 2; the third is accepted only after the first yumi; response order is preserved; req_count_o=3.
6. Assert reset_n_i low with 2 responses queued -> resp_v_o, flags and counter 0 asynchronously; load of an unmapped EPA after release returns 'hDEAD_BEEF.

Source files
------------

// File: rtl/bsg_manycore_host_ep_responder_pkg.sv
// Shared types and default EPA map for the host endpoint responder.
package bsg_manycore_host_ep_pkg;

  typedef enum logic [1:0] {
    e_host_ep_load  = 2'd0,
    e_host_ep_store = 2'd1
  } host_ep_op_e;

  typedef enum logic {
    e_host_ep_ack       = 1'b0,
    e_host_ep_load_data = 1'b1
  } host_ep_resp_type_e;

  localparam int host_ep_print_stat_epa_gp = 'h0D0C;
  localparam int host_ep_putchar_epa_gp    = 'h1000;
  localparam int host_ep_finish_epa_gp     = 'h3AB4;
  localparam int host_ep_fail_epa_gp       = 'h3AB8;

  localparam logic [31:0] host_ep_dead_beef_gp = 32'hDEAD_BEEF;

endpackage

// File: rtl/bsg_manycore_host_ep_responder_if.sv
// Request/response link between the host link adapter (master) and the endpoint (slave).
interface bsg_manycore_host_ep_responder_if #(
  parameter int addr_width_p   = 28,
  parameter int data_width_p   = 32,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7
) ();

  logic                      req_v;
  logic                      req_ready;
  logic [1:0]                req_op;
  logic [addr_width_p-1:0]   req_addr;
  logic [data_width_p-1:0]   req_data;
  logic [data_width_p/8-1:0] req_mask;
  logic [4:0]                req_reg_id;
  logic [x_cord_width_p-1:0] req_src_x;
  logic [y_cord_width_p-1:0] req_src_y;

  logic                      resp_v;
  logic                      resp_yumi;
  logic                      resp_type;
  logic [data_width_p-1:0]   resp_data;
  logic [4:0]                resp_reg_id;
  logic [x_cord_width_p-1:0] resp_dst_x;
  logic [y_cord_width_p-1:0] resp_dst_y;

  modport master (
    output req_v, req_op, req_addr, req_data, req_mask, req_reg_id, req_src_x, req_src_y,
    output resp_yumi,
    input  req_ready,
    input  resp_v, resp_type, resp_data, resp_reg_id, resp_dst_x, resp_dst_y
  );

  modport slave (
    input  req_v, req_op, req_addr, req_data, req_mask, req_reg_id, req_src_x, req_src_y,
    input  resp_yumi,
    output req_ready,
    output resp_v, resp_type, resp_data, resp_reg_id, resp_dst_x, resp_dst_y
  );

endinterface

// File: rtl/bsg_manycore_host_ep_resp_fifo.sv
// Two-entry response FIFO; ready and valid come only from registered occupancy.
module bsg_manycore_host_ep_resp_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem_r [2];
  logic               wr_ptr_r;
  logic               rd_ptr_r;
  logic [1:0]         count_r;
  logic               enq;
  logic               deq;

  assign ready_o = (count_r != 2'd2);
  assign v_o     = (count_r != 2'd0);
  assign data_o  = mem_r[rd_ptr_r];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (enq) begin
        mem_r[wr_ptr_r] <= data_i;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (deq) rd_ptr_r <= ~rd_ptr_r;
      case ({enq, deq})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/bsg_manycore_host_ep_responder.sv
// Host-tile endpoint: decodes remote loads/stores against the fixed EPA map,
// updates scratch/status state and queues one response per request.
module bsg_manycore_host_ep_responder
  import bsg_manycore_host_ep_pkg::*;
#(
  parameter int addr_width_p     = 28,
  parameter int data_width_p     = 32,
  parameter int x_cord_width_p   = 7,
  parameter int y_cord_width_p   = 7,
  parameter int scratch_words_p  = 16,
  parameter int print_stat_epa_p = host_ep_print_stat_epa_gp,
  parameter int putchar_epa_p    = host_ep_putchar_epa_gp,
  parameter int finish_epa_p     = host_ep_finish_epa_gp,
  parameter int fail_epa_p       = host_ep_fail_epa_gp
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  bsg_manycore_host_ep_responder_if.slave ep,
  output logic                    print_stat_v_o,
  output logic [data_width_p-1:0] print_stat_tag_o,
  output logic                    putchar_v_o,
  output logic [7:0]              putchar_o,
  output logic                    finish_o,
  output logic                    fail_o,
  output logic [data_width_p-1:0] exit_code_o,
  output logic [31:0]             req_count_o
);

  localparam int mask_width_lp  = data_width_p / 8;
  localparam int idx_width_lp   = $clog2(scratch_words_p);
  localparam int entry_width_lp = 1 + data_width_p + 5 + x_cord_width_p + y_cord_width_p;

  logic                      fifo_ready;
  logic                      accept;
  logic                      is_load;
  logic                      store_accept;
  logic                      scratch_hit;
  logic                      hit_print_stat;
  logic                      hit_putchar;
  logic                      hit_finish;
  logic                      hit_fail;
  logic [idx_width_lp-1:0]   scratch_idx;
  logic [data_width_p-1:0]   scratch_r [scratch_words_p];
  logic [data_width_p-1:0]   load_data;
  host_ep_resp_type_e        resp_type;
  logic [entry_width_lp-1:0] enq_entry;
  logic [entry_width_lp-1:0] deq_entry;

  assign accept         = ep.req_v & fifo_ready;
  assign ep.req_ready   = fifo_ready;
  // Reserved ops 2/3 fall through to store handling.
  assign is_load        = (host_ep_op_e'(ep.req_op) == e_host_ep_load);
  assign store_accept   = accept & ~is_load;
  assign scratch_hit    = (ep.req_addr < addr_width_p'(scratch_words_p));
  assign hit_print_stat = (ep.req_addr == addr_width_p'(print_stat_epa_p));
  assign hit_putchar    = (ep.req_addr == addr_width_p'(putchar_epa_p));
  assign hit_finish     = (ep.req_addr == addr_width_p'(finish_epa_p));
  assign hit_fail       = (ep.req_addr == addr_width_p'(fail_epa_p));
  assign scratch_idx    = ep.req_addr[idx_width_lp-1:0];

  always_comb begin
    load_data = data_width_p'(host_ep_dead_beef_gp);
    if (scratch_hit)         load_data = scratch_r[scratch_idx];
    else if (hit_print_stat) load_data = '0;
    else if (hit_finish)     load_data = data_width_p'(finish_o);
    else if (hit_fail)       load_data = data_width_p'(fail_o);
  end

  assign resp_type = is_load ? e_host_ep_load_data : e_host_ep_ack;
  assign enq_entry = {resp_type, (is_load ? load_data : '0), ep.req_reg_id,
                      ep.req_src_x, ep.req_src_y};

  bsg_manycore_host_ep_resp_fifo #(.width_p(entry_width_lp)) resp_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .data_i    (enq_entry),
    .v_i       (ep.req_v),
    .ready_o   (fifo_ready),
    .data_o    (deq_entry),
    .v_o       (ep.resp_v),
    .yumi_i    (ep.resp_yumi)
  );

  assign {ep.resp_type, ep.resp_data, ep.resp_reg_id, ep.resp_dst_x, ep.resp_dst_y} = deq_entry;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < scratch_words_p; i++) scratch_r[i] <= '0;
    end else if (store_accept && scratch_hit) begin
      for (int b = 0; b < mask_width_lp; b++)
        if (ep.req_mask[b]) scratch_r[scratch_idx][b*8 +: 8] <= ep.req_data[b*8 +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      print_stat_v_o   <= 1'b0;
      print_stat_tag_o <= '0;
      putchar_v_o      <= 1'b0;
      putchar_o        <= '0;
      finish_o         <= 1'b0;
      fail_o           <= 1'b0;
      exit_code_o      <= '0;
      req_count_o      <= '0;
    end else begin
      print_stat_v_o <= store_accept & hit_print_stat;
      putchar_v_o    <= store_accept & hit_putchar;
      if (store_accept && hit_print_stat) print_stat_tag_o <= ep.req_data;
      if (store_accept && hit_putchar)    putchar_o        <= ep.req_data[7:0];
      // Exit code latches only on the first finish-or-fail store.
      if (store_accept && (hit_finish || hit_fail)) begin
        if (!finish_o && !fail_o) exit_code_o <= ep.req_data;
        if (hit_finish) finish_o <= 1'b1;
        if (hit_fail)   fail_o   <= 1'b1;
      end
      if (accept) req_count_o <= req_count_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_bsg_manycore_host_ep_responder.sv
// Randomized and directed bench for the host endpoint responder against a queue-based model.
module tb_bsg_manycore_host_ep_responder;
  import bsg_manycore_host_ep_pkg::*;

  localparam logic [27:0] PS_EPA  = 28'h0D0C;
  localparam logic [27:0] PC_EPA  = 28'h1000;
  localparam logic [27:0] FIN_EPA = 28'h3AB4;
  localparam logic [27:0] FL_EPA  = 28'h3AB8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bsg_manycore_host_ep_responder_if ep();

  logic        print_stat_v, putchar_v, finish, fail;
  logic [31:0] print_stat_tag, exit_code, req_count;
  logic [7:0]  putchar;

  bsg_manycore_host_ep_responder dut (
    .clk_i            (clk),
    .reset_n_i        (rst_n),
    .ep               (ep),
    .print_stat_v_o   (print_stat_v),
    .print_stat_tag_o (print_stat_tag),
    .putchar_v_o      (putchar_v),
    .putchar_o        (putchar),
    .finish_o         (finish),
    .fail_o           (fail),
    .exit_code_o      (exit_code),
    .req_count_o      (req_count)
  );

  typedef struct {
    bit          typ;
    logic [31:0] data;
    logic [4:0]  rid;
    logic [6:0]  x;
    logic [6:0]  y;
  } resp_t;

  resp_t       q[$];
  logic [31:0] m_scr [16];
  bit          m_fin, m_fail, m_ps_v, m_pc_v, m_acc;
  logic [31:0] m_exit, m_cnt, m_ps_tag;
  logic [7:0]  m_pc;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 16; i++) m_scr[i] = '0;
    m_fin = 0; m_fail = 0; m_ps_v = 0; m_pc_v = 0; m_acc = 0;
    m_exit = '0; m_cnt = '0; m_ps_tag = '0; m_pc = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [27:0] a);
    if (a < 28'd16)   return m_scr[a[3:0]];
    if (a == PS_EPA)  return 32'h0;
    if (a == FIN_EPA) return {31'b0, m_fin};
    if (a == FL_EPA)  return {31'b0, m_fail};
    return 32'hDEAD_BEEF;
  endfunction

  // Advance the model by one clock using the inputs presented in that cycle.
  task automatic model_clock();
    bit          acc, deq, st;
    resp_t       r;
    logic [27:0] a;
    logic [31:0] d;
    acc = ep.req_v && (q.size() < 2);
    deq = ep.resp_yumi && (q.size() > 0);
    st  = (ep.req_op != 2'd0);
    a   = ep.req_addr;
    d   = ep.req_data;
    m_ps_v = acc && st && (a == PS_EPA);
    m_pc_v = acc && st && (a == PC_EPA);
    if (m_ps_v) m_ps_tag = d;
    if (m_pc_v) m_pc = d[7:0];
    r.typ  = !st;
    r.data = st ? 32'h0 : model_read(a);
    r.rid  = ep.req_reg_id;
    r.x    = ep.req_src_x;
    r.y    = ep.req_src_y;
    if (acc && st) begin
      if (a < 28'd16)
        for (int b = 0; b < 4; b++)
          if (ep.req_mask[b]) m_scr[a[3:0]][b*8 +: 8] = d[b*8 +: 8];
      if (a == FIN_EPA || a == FL_EPA) begin
        if (!m_fin && !m_fail) m_exit = d;
        if (a == FIN_EPA) m_fin = 1;
        else              m_fail = 1;
      end
    end
    if (acc) m_cnt = m_cnt + 32'd1;
    if (deq) void'(q.pop_front());
    if (acc) q.push_back(r);
    m_acc = acc;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_ready", ep.req_ready, q.size() < 2);
      chk("resp_v", ep.resp_v, q.size() != 0);
      if (q.size() != 0) begin
        chk("resp_type", ep.resp_type, q[0].typ);
        chk("resp_data", ep.resp_data, q[0].data);
        chk("resp_reg_id", ep.resp_reg_id, q[0].rid);
        chk("resp_dst_x", ep.resp_dst_x, q[0].x);
        chk("resp_dst_y", ep.resp_dst_y, q[0].y);
      end
      chk("print_stat_v", print_stat_v, m_ps_v);
      if (m_ps_v) chk("print_stat_tag", print_stat_tag, m_ps_tag);
      chk("putchar_v", putchar_v, m_pc_v);
      if (m_pc_v) chk("putchar", putchar, m_pc);
      chk("finish", finish, m_fin);
      chk("fail", fail, m_fail);
      chk("exit_code", exit_code, m_exit);
      chk("req_count", req_count, m_cnt);
    end
  end

  task automatic step(input bit v, input bit [1:0] op, input bit [27:0] a, input bit [31:0] d,
                      input bit [3:0] m, input bit [4:0] rid, input bit [6:0] x, input bit [6:0] y,
                      input bit yumi);
    @(negedge clk);
    ep.req_v = v; ep.req_op = op; ep.req_addr = a; ep.req_data = d; ep.req_mask = m;
    ep.req_reg_id = rid; ep.req_src_x = x; ep.req_src_y = y; ep.resp_yumi = yumi;
    @(posedge clk);
    model_clock();
  endtask

  task automatic idle(input bit yumi);
    step(0, 2'd0, 28'h0, 32'h0, 4'h0, 5'd0, 7'd0, 7'd0, yumi);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ep.req_v = 0; ep.resp_yumi = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
  endtask

  initial begin
    ep.req_v = 0; ep.req_op = 0; ep.req_addr = 0; ep.req_data = 0; ep.req_mask = 0;
    ep.req_reg_id = 0; ep.req_src_x = 0; ep.req_src_y = 0; ep.resp_yumi = 0;
    model_reset();
    do_reset();
    #1;
    chk("rst_ready", ep.req_ready, 1'b1);
    chk("rst_resp_v", ep.resp_v, 1'b0);
    chk("rst_count", req_count, 32'h0);

    // Store then load scratch word 3.
    step(1, 2'd1, 28'd3, 32'h1234_5678, 4'hF, 5'd0, 7'd0, 7'd0, 0);
    step(1, 2'd0, 28'd3, 32'h0, 4'h0, 5'd7, 7'd2, 7'd5, 0);
    #2 chk("t1_ack_type", ep.resp_type, 1'b0);
    idle(1);
    #2;
    chk("t1_load_type", ep.resp_type, 1'b1);
    chk("t1_load_data", ep.resp_data, 32'h1234_5678);
    chk("t1_reg_id", ep.resp_reg_id, 5'd7);
    chk("t1_dst_x", ep.resp_dst_x, 7'd2);
    chk("t1_dst_y", ep.resp_dst_y, 7'd5);
    idle(1);

    // Byte-masked store.
    step(1, 2'd1, 28'd4, 32'hAABB_CCDD, 4'b0101, 5'd0, 7'd0, 7'd0, 1);
    step(1, 2'd0, 28'd4, 32'h0, 4'h0, 5'd1, 7'd0, 7'd0, 1);
    #2 chk("t2_masked", ep.resp_data, 32'h00BB_00DD);
    idle(1);

    // Putchar and print-stat pulses.
    step(1, 2'd1, PC_EPA, 32'h2A, 4'h0, 5'd0, 7'd0, 7'd0, 1);
    #2;
    chk("t3_pc_v", putchar_v, 1'b1);
    chk("t3_pc", putchar, 8'h2A);
    step(1, 2'd1, PS_EPA, 32'h7, 4'h0, 5'd0, 7'd0, 7'd0, 1);
    #2;
    chk("t3_pc_v_drop", putchar_v, 1'b0);
    chk("t3_ps_v", print_stat_v, 1'b1);
    chk("t3_ps_tag", print_stat_tag, 32'h7);
    idle(1);
    #2 chk("t3_ps_v_drop", print_stat_v, 1'b0);

    // Finish then fail; exit code keeps the first.
    step(1, 2'd1, FIN_EPA, 32'd5, 4'h0, 5'd0, 7'd0, 7'd0, 1);
    step(1, 2'd1, FL_EPA, 32'd9, 4'h0, 5'd0, 7'd0, 7'd0, 1);
    step(1, 2'd0, FIN_EPA, 32'h0, 4'h0, 5'd3, 7'd0, 7'd0, 1);
    #2;
    chk("t4_finish", finish, 1'b1);
    chk("t4_fail", fail, 1'b1);
    chk("t4_exit", exit_code, 32'd5);
    chk("t4_load_fin", ep.resp_data, 32'd1);
    idle(1);

    // Backpressure: third request waits for the first yumi.
    do_reset();
    step(1, 2'd0, 28'd0, 32'h0, 4'h0, 5'd1, 7'd0, 7'd0, 0);
    step(1, 2'd0, 28'd1, 32'h0, 4'h0, 5'd2, 7'd0, 7'd0, 0);
    #2 chk("t5_ready_full", ep.req_ready, 1'b0);
    step(1, 2'd0, 28'd2, 32'h0, 4'h0, 5'd3, 7'd0, 7'd0, 0);
    begin
      bit got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
        step(1, 2'd0, 28'd2, 32'h0, 4'h0, 5'd3, 7'd0, 7'd0, i == 0);
        got = m_acc;
      end
      chk("t5_third_accepted", got, 1'b1);
    end
    #2;
    chk("t5_count", req_count, 32'd3);
    chk("t5_head_rid", ep.resp_reg_id, 5'd2);
    idle(1);
    #2 chk("t5_next_rid", ep.resp_reg_id, 5'd3);

    // Asynchronous reset with two responses queued.
    step(1, 2'd1, FIN_EPA, 32'h11, 4'h0, 5'd0, 7'd0, 7'd0, 1);
    step(1, 2'd0, 28'd5, 32'h0, 4'h0, 5'd9, 7'd0, 7'd0, 0);
    #2;
    chk("t6_pre_finish", finish, 1'b1);
    chk("t6_pre_full", ep.req_ready, 1'b0);
    #1 rst_n = 0;
    model_reset();
    #1;
    chk("t6_resp_v", ep.resp_v, 1'b0);
    chk("t6_finish", finish, 1'b0);
    chk("t6_exit", exit_code, 32'h0);
    chk("t6_count", req_count, 32'h0);
    @(posedge clk);
    #3 rst_n = 1;
    step(1, 2'd0, 28'h5555, 32'h0, 4'h0, 5'd4, 7'd1, 7'd1, 0);
    #2 chk("t6_dead_beef", ep.resp_data, 32'hDEAD_BEEF);
    idle(1);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bit [27:0] a;
      bit [1:0]  op;
      if (i == 750) do_reset();
      case ($urandom_range(0, 7))
        0, 1, 2: a = 28'($urandom_range(0, 15));
        3:       a = PS_EPA;
        4:       a = PC_EPA;
        5:       a = (i < 1200) ? 28'd16 : FIN_EPA;
        6:       a = (i < 1100) ? 28'h7FF : FL_EPA;
        default: a = 28'($urandom);
      endcase
      op = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      if ($urandom_range(0, 1) == 0) op = 2'd1;
      step($urandom_range(0, 3) != 0, op, a, $urandom, 4'($urandom), 5'($urandom),
           7'($urandom), 7'($urandom), $urandom_range(0, 9) < 7);
    end
    repeat (4) idle(1);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
